// File: rtl/fsm_seq_ctrl.sv
// Sequencing controller: replays {symbol, expected state} entries from a FIFO into a 4-bit Moore FSM core.
// Optional expected-state checking is enabled with the FSM_SEQ_CHECK_EN macro.
module fsm_seq_ctrl #(
  parameter int DEPTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic [3:0]  fsm_in,
  output logic        fsm_step,
  input  logic [3:0]  fsm_state,
  output logic        busy,
  output logic        done,
  output logic [15:0] step_cnt,
  output logic [15:0] err_cnt,
  output logic        err,
  output logic [15:0] err_step,
  output logic [2:0]  dbg_state
);
  localparam int AW = $clog2(DEPTH);
`ifdef FSM_SEQ_CHECK_EN
  localparam int DW = 8;
`else
  localparam int DW = 4;
`endif
  localparam logic [3:0] SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Handshake: an entry transfers on a rising edge where s_valid && s_ready and abort is low.
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  logic [DW-1:0] head;
  logic [2:0]    state, state_nxt;
  logic [3:0]    settle_cnt;
  logic          step_r;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_ready = !full;
  assign push    = s_valid && s_ready && !abort;
  assign pop     = (state == S_ISSUE) && !abort;
  assign head    = mem[rd_ptr[AW-1:0]];
  // An abort landing in the ISSUE cycle must cancel the step already on the wire.
  assign fsm_step  = step_r && !abort;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_data[7 -: DW];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start && !empty) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = (SETTLE > 0) ? S_SETTLE : S_CHECK;
      S_SETTLE: if (settle_cnt == 4'd0) state_nxt = S_CHECK;
      // A push arriving this same cycle is not yet in the occupancy and does not extend the run.
      S_CHECK:  state_nxt = empty ? S_DONE : S_ISSUE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_r     <= 1'b0;
      fsm_in     <= 4'd0;
      settle_cnt <= 4'd0;
      step_cnt   <= 16'd0;
    end else begin
      state  <= state_nxt;
      busy   <= (state_nxt != S_IDLE);
      done   <= (state_nxt == S_DONE);
      step_r <= (state_nxt == S_ISSUE);
      if (abort) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      // The symbol is loaded on entry to ISSUE so the core sees it during the step cycle.
      if (state_nxt == S_ISSUE) fsm_in <= head[DW-1 -: 4];
      if (state == S_ISSUE) settle_cnt <= SETTLE_LOAD;
      else if (state == S_SETTLE && settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
      if (state == S_IDLE && state_nxt == S_ISSUE) step_cnt <= 16'd0;
      else if (state == S_CHECK && step_cnt != 16'hFFFF) step_cnt <= step_cnt + 16'd1;
    end
  end

`ifdef FSM_SEQ_CHECK_EN
  logic [3:0] exp_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_r    <= 4'd0;
      err_cnt  <= 16'd0;
      err      <= 1'b0;
      err_step <= 16'd0;
    end else begin
      if (state_nxt == S_ISSUE) exp_r <= head[3:0];
      if (state == S_IDLE && state_nxt == S_ISSUE) begin
        err_cnt  <= 16'd0;
        err      <= 1'b0;
        err_step <= 16'd0;
      end else if (state == S_CHECK && fsm_state != exp_r) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (!err) begin
          err      <= 1'b1;
          err_step <= step_cnt;
        end
      end
    end
  end
`else
  logic unused_check_inputs;
  assign unused_check_inputs = ^{s_data[3:0], fsm_state};
  assign err_cnt  = 16'd0;
  assign err      = 1'b0;
  assign err_step = 16'd0;
`endif

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Scoreboard bench for fsm_seq_ctrl with a small Moore core model; a second instance runs with SETTLE=0.
module tb_fsm_seq_ctrl;
  localparam int SETTLE = 1;
`ifdef FSM_SEQ_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_ready, fsm_step, busy, done, err;
  logic [3:0]  fsm_in, core_state;
  logic [15:0] step_cnt, err_cnt, err_step;
  logic [2:0]  dbg_state;

  logic        start_0 = 1'b0, abort_0 = 1'b0, s_valid_0 = 1'b0;
  logic [7:0]  s_data_0 = 8'd0;
  logic [3:0]  fsm_state_0 = 4'd0;
  logic        s_ready_0, fsm_step_0, busy_0, done_0, err_0;
  logic [3:0]  fsm_in_0;
  logic [15:0] step_cnt_0, err_cnt_0, err_step_0;
  logic [2:0]  dbg_state_0;

  int n_vec = 0, n_mis = 0, cyc = 0, done_cnt = 0;
  int prev_cyc = 0, issue0 = 0, steps_in_run = 0;
  bit have_prev = 0;
  logic [3:0] pred = 4'd0;
  logic [3:0] exp_q[$];

  fsm_seq_ctrl #(.DEPTH(8), .SETTLE(SETTLE)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .fsm_in(fsm_in), .fsm_step(fsm_step),
    .fsm_state(core_state), .busy(busy), .done(done), .step_cnt(step_cnt),
    .err_cnt(err_cnt), .err(err), .err_step(err_step), .dbg_state(dbg_state));

  fsm_seq_ctrl #(.DEPTH(8), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_0), .abort(abort_0), .s_valid(s_valid_0),
    .s_ready(s_ready_0), .s_data(s_data_0), .fsm_in(fsm_in_0), .fsm_step(fsm_step_0),
    .fsm_state(fsm_state_0), .busy(busy_0), .done(done_0), .step_cnt(step_cnt_0),
    .err_cnt(err_cnt_0), .err(err_0), .err_step(err_step_0), .dbg_state(dbg_state_0));

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  // Core model: next state depends on state ^ symbol (0^8->6, 6^2->5, 5^C->0)
  function automatic logic [3:0] core_next(input logic [3:0] s, input logic [3:0] sym);
    logic [3:0] x;
    x = s ^ sym;
    case (x)
      4'h8:    core_next = 4'h6;
      4'h4:    core_next = 4'h5;
      4'h9:    core_next = 4'h0;
      default: core_next = x + 4'h3;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) core_state <= 4'd0;
    else if (fsm_step) core_state <= core_next(core_state, fsm_in);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n || abort) begin
      have_prev    = 0;
      steps_in_run = 0;
    end else begin
      if (fsm_step) begin
        if (exp_q.size() == 0) chk("step_extra", 1, 0);
        else chk("fsm_in", fsm_in, exp_q.pop_front());
        if (have_prev) chk("step_gap", cyc - prev_cyc, SETTLE + 2);
        else issue0 = cyc;
        have_prev = 1;
        prev_cyc  = cyc;
        steps_in_run++;
      end
      if (done) begin
        done_cnt++;
        // ISSUE..DONE spans N*(SETTLE+2)+1 cycles inclusive
        chk("done_lat", cyc - issue0, steps_in_run * (SETTLE + 2));
        chk("drained", exp_q.size(), 0);
        chk("step_cnt_run", step_cnt, steps_in_run);
        have_prev    = 0;
        steps_in_run = 0;
      end
    end
  end

  // Driver tasks
  task automatic push(input logic [3:0] sym, input logic [3:0] ex, input bit acc);
    @(negedge clk);
    s_data  = {sym, ex};
    s_valid = 1'b1;
    chk("s_ready", s_ready, acc);
    @(posedge clk);
    #1 s_valid = 1'b0;
    if (acc) begin
      exp_q.push_back(sym);
      pred = core_next(pred, sym);
    end
  endtask

  task automatic push_auto(input logic [3:0] sym, input bit acc);
    push(sym, core_next(pred, sym), acc);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    chk("done_seen", done, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_fsm_in", fsm_in, 0);
    chk("rst_fsm_step", fsm_step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_err_step", err_step, 0);
    chk("rst_state", dbg_state, 0);
  endtask

  int first0, last0, nsteps0, dsave;
  bit got0;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals();

    // start with an empty FIFO is ignored
    dsave = done_cnt;
    pulse_start();
    @(negedge clk);
    chk("empty_start_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("empty_start_done", done_cnt, dsave);

    // basic three-step run
    push(4'b1000, 4'b0110, 1);
    push(4'b0010, 4'b0101, 1);
    push(4'b1100, 4'b0000, 1);
    pulse_start();
    wait_done(40);
    chk("t1_step_cnt", step_cnt, 3);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_err", err, 0);
    @(posedge clk);

    // wrong expectation on the first step
    push(4'b1000, 4'b0111, 1);
    push(4'b0010, 4'b0101, 1);
    pulse_start();
    wait_done(40);
    chk("t2_step_cnt", step_cnt, 2);
    chk("t2_err", err, CHK_EN ? 1 : 0);
    chk("t2_err_step", err_step, 0);
    chk("t2_err_cnt", err_cnt, CHK_EN ? 1 : 0);
    @(posedge clk);

    // fill: 8 accepted, 9th dropped
    for (int i = 0; i < 9; i++) push_auto(4'($urandom_range(0, 15)), i < 8);
    @(negedge clk);
    chk("t3_full_ready", s_ready, 0);
    pulse_start();
    wait_done(80);
    chk("t3_step_cnt", step_cnt, 8);
    chk("t3_err_cnt", err_cnt, 0);
    @(posedge clk);

    // pushes during the run extend it
    push_auto(4'($urandom_range(0, 15)), 1);
    push_auto(4'($urandom_range(0, 15)), 1);
    pulse_start();
    for (int i = 0; i < 5; i++) push_auto(4'b1111, 1);
    wait_done(80);
    chk("t4_step_cnt", step_cnt, 7);
    chk("t4_err_cnt", err_cnt, 0);
    @(posedge clk);

    // abort in the second ISSUE
    for (int i = 0; i < 4; i++) push_auto(4'($urandom_range(0, 15)), 1);
    dsave = done_cnt;
    pulse_start();
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("t5_step_cancel", fsm_step, 0);
    chk("t5_one_step_done", exp_q.size(), 3);
    @(posedge clk);
    #1 abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_step_cnt", step_cnt, 1);
    chk("t5_ready", s_ready, 1);
    pulse_start();
    @(negedge clk);
    chk("t5_fifo_empty", busy, 0);
    repeat (2) @(negedge clk);
    chk("t5_no_done", done_cnt, dsave);

    // SETTLE=0 instance: 2-cycle step period
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid_0 = 1'b1;
      s_data_0  = {4'(i + 3), 4'd0};
      @(posedge clk);
      #1 s_valid_0 = 1'b0;
    end
    @(negedge clk);
    start_0 = 1'b1;
    @(posedge clk);
    #1 start_0 = 1'b0;
    first0 = -1; last0 = -1; nsteps0 = 0; got0 = 0;
    for (int n = 0; n < 40 && !got0; n++) begin
      @(negedge clk);
      if (fsm_step_0) begin
        if (last0 >= 0) chk("s0_step_gap", cyc - last0, 2);
        if (first0 < 0) first0 = cyc;
        chk("s0_fsm_in", fsm_in_0, nsteps0 + 3);
        last0 = cyc;
        nsteps0++;
      end
      if (done_0) begin
        got0 = 1;
        chk("s0_done_lat", cyc - first0, 8);
        chk("s0_step_cnt", step_cnt_0, 4);
      end
    end
    chk("s0_done_seen", got0, 1);
    chk("s0_steps", nsteps0, 4);

    // reset mid-run
    for (int i = 0; i < 3; i++) push_auto(4'($urandom_range(0, 15)), 1);
    dsave = done_cnt;
    pulse_start();
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    pred = 4'd0;
    @(negedge clk);
    chk_reset_vals();
    pulse_start();
    @(negedge clk);
    chk("t6_start_ignored", busy, 0);
    repeat (2) @(negedge clk);
    chk("t6_no_done", done_cnt, dsave);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
